key_encoder_83: RTL



---
 rtl/key_encoder_83_if.sv | 25 ++
 rtl/key_encoder_83.sv | 117 +++++++++++
 2 files changed

// File: rtl/key_encoder_83_if.sv
// Button-to-key-code bundle: raw active-low pins in, debounced code/strobe/count out.
// The master side is the encoder; the slave side is the consumer that drives the pins.
interface key_encoder_83_if;
  logic [7:0] key_n;
  logic [2:0] key_code;
  logic       key_valid;
  logic       key_strobe;
  logic [7:0] press_count;

  modport master (
    input  key_n,
    output key_code,
    output key_valid,
    output key_strobe,
    output press_count
  );

  modport slave (
    output key_n,
    input  key_code,
    input  key_valid,
    input  key_strobe,
    input  press_count
  );
endinterface

// File: rtl/key_encoder_83.sv
// Eight active-low buttons -> synchronized, debounced, priority-encoded 3-bit key code
// with a one-cycle press strobe and a wrapping 8-bit press counter.
module key_encoder_83 #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  key_encoder_83_if.master bus
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] DB_PRESS   = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;
  localparam logic [1:0] DB_RELEASE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]       ALL_UP   = 8'hFF;

  logic [7:0]       sync1_reg;
  logic [7:0]       sync2_reg;
  logic [1:0]       state_reg;
  logic [CNT_W-1:0] counter_reg;
  logic [7:0]       snapshot_reg;
  logic [2:0]       key_code_reg;
  logic             key_valid_reg;
  logic             key_strobe_reg;
  logic [7:0]       press_count_reg;

  // Two-flop synchronizer per pin; idles high so reset looks like "no key".
  for (genvar gi = 0; gi < 8; gi++) begin : g_sync
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_reg[gi] <= 1'b1;
        sync2_reg[gi] <= 1'b1;
      end else begin
        sync1_reg[gi] <= bus.key_n[gi];
        sync2_reg[gi] <= sync1_reg[gi];
      end
    end
  end

  // Lowest-numbered pressed key wins.
  function automatic logic [2:0] encode(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      counter_reg     <= '0;
      snapshot_reg    <= ALL_UP;
      key_code_reg    <= 3'd0;
      key_valid_reg   <= 1'b0;
      key_strobe_reg  <= 1'b0;
      press_count_reg <= 8'd0;
    end else begin
      key_strobe_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sync2_reg != ALL_UP) begin
            state_reg    <= DB_PRESS;
            snapshot_reg <= sync2_reg;
            counter_reg  <= '0;
          end
        end
        DB_PRESS: begin
          if (sync2_reg == ALL_UP) begin
            state_reg <= IDLE;
          end else if (sync2_reg != snapshot_reg) begin
            // Key pattern moved mid-debounce: restart timing on the new pattern.
            snapshot_reg <= sync2_reg;
            counter_reg  <= '0;
          end else if (counter_reg == CNT_LAST) begin
            state_reg       <= HELD;
            key_code_reg    <= encode(snapshot_reg);
            key_valid_reg   <= 1'b1;
            key_strobe_reg  <= 1'b1;
            press_count_reg <= press_count_reg + 8'd1;
          end else begin
            counter_reg <= counter_reg + 1'b1;
          end
        end
        HELD: begin
          if (sync2_reg == ALL_UP) begin
            state_reg   <= DB_RELEASE;
            counter_reg <= '0;
          end
        end
        DB_RELEASE: begin
          if (sync2_reg != ALL_UP) begin
            // Release bounce: fall back to HELD without a new strobe.
            state_reg   <= HELD;
            counter_reg <= '0;
          end else if (counter_reg == CNT_LAST) begin
            state_reg     <= IDLE;
            key_valid_reg <= 1'b0;
          end else begin
            counter_reg <= counter_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.key_code    = key_code_reg;
  assign bus.key_valid   = key_valid_reg;
  assign bus.key_strobe  = key_strobe_reg;
  assign bus.press_count = press_count_reg;

endmodule
